gpr_wb_arb: RTL
===============

GPR_WB_ARB -- requirements
Module: gpr_wb_arb

Interface
REQ-001 SHALL have parameter REG_NUM, default 32: count of GPR addresses written by a clear sequence (1..32).
REQ-002 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port req0_valid, input, 1: requester 0 has a writeback pending.
REQ-005 SHALL have ports req0_addr (input, 5) and req0_data (input, 32): requester 0 target register and value.
REQ-006 SHALL have port req0_ready, output, 1: requester 0 writeback accepted this cycle.
REQ-007 SHALL have ports req1_valid (input, 1), req1_addr (input, 5), req1_data (input, 32) and req1_ready (output, 1): same meanings for requester 1.
REQ-008 SHALL have port clr_start, input, 1: one-cycle request to zero GPR addresses 0..REG_NUM-1.
REQ-009 SHALL have port clr_busy, output, 1: clear sequence in progress.
REQ-010 SHALL have port clr_done, output, 1: one-cycle pulse marking the final clear write.
REQ-011 SHALL have port we_, output, 1: GPR write enable, active-low (0 = write).
REQ-012 SHALL have ports wr_addr (output, 5) and wr_data (output, 32): GPR write address and data.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-014 In IDLE, a handshake SHALL complete when reqN_valid and reqN_ready are both 1 in the same cycle; reqN_ready SHALL be combinational.
REQ-015 In IDLE with clr_start=0, exactly one requester SHALL be granted when at least one is valid; a lone valid requester SHALL be granted.
REQ-016 When both are valid, grant SHALL be round-robin: the requester not granted last SHALL win; pointer last_gnt SHALL update only on a completed handshake.
REQ-017 reqN_ready SHALL be 0 when reqN_valid=0; a requester SHALL NOT be granted in a cycle where it is not valid.
REQ-018 An accepted request SHALL appear on the write port the following cycle: we_=0, wr_addr/wr_data = accepted values, registered.
REQ-019 In any cycle with no accepted request and no clear write, the next-cycle we_ SHALL be 1; wr_addr and wr_data SHALL hold their previous values.
REQ-020 Sustained throughput SHALL be one GPR write per cycle; no bubble between back-to-back grants.
REQ-021 clr_start=1 in IDLE SHALL move the FSM to CLEAR next cycle; both ready outputs SHALL be 0 in that cycle (clear wins over a simultaneous request).
REQ-022 In CLEAR, counter cnt SHALL step 0..REG_NUM-1, one per cycle; each step SHALL register we_=0, wr_addr=cnt, wr_data=0 for the next cycle.
REQ-023 After the step with cnt=REG_NUM-1, the FSM SHALL return to IDLE and cnt SHALL return to 0.
REQ-024 In CLEAR, both ready outputs SHALL be 0 and clr_start SHALL be ignored.
REQ-025 clr_busy SHALL equal (state==CLEAR), combinational.
REQ-026 clr_done SHALL be registered and 1 in exactly the cycle the write port presents wr_addr=REG_NUM-1 from the clear.
REQ-027 Requests held valid through CLEAR SHALL be served normally from the first IDLE cycle, with data unchanged.

Reset
REQ-028 On reset=1 at a rising edge: state=IDLE, cnt=0, last_gnt=1 (requester 0 wins the first tie), we_=1, wr_addr=0, wr_data=0, clr_done=0.
REQ-029 Reset during CLEAR SHALL abort the sequence with no further clear writes and no clr_done pulse.
REQ-030 While reset=1, both ready outputs SHALL be 0.

Verification
REQ-031 After reset, req0 valid (addr 3, data 0x11111111) and req1 valid (addr 4, data 0x22222222), both held -> grants alternate 0,1,0,...; next-cycle writes: r3=0x11111111 then r4=0x22222222, we_=0 on consecutive cycles.
REQ-032 Only req1 valid for 3 cycles (addr 7, data 0xA5A5A5A5) -> req1_ready=1 each cycle; three writes to r7, with we_=0 in the cycles following acceptance.
REQ-033 clr_start pulse in IDLE with req0 valid the same cycle -> req0_ready=0; 32 writes of 0 to addresses 0..31; clr_busy=1 for 32 cycles; clr_done=1 only alongside the addr-31 write; req0 accepted on the first IDLE cycle.
REQ-034 clr_start asserted again mid-clear -> no restart; exactly 32 clear writes, one clr_done.
REQ-035 reset asserted at clear step cnt=10 -> next cycle we_=1, clr_busy=0, no clr_done; a following req0 is accepted immediately.
REQ-036 No valid inputs for 5 cycles after a write -> we_=1 throughout; wr_addr/wr_data hold the last written values.

Source files
------------

// File: rtl/gpr_wb_arb.sv
// rtl/gpr_wb_arb.sv - two-requester GPR writeback arbiter with register-file clear sequencer
module gpr_wb_arb #(
    parameter int REG_NUM = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    input  logic        clr_start,
    output logic        clr_busy,
    output logic        clr_done,
    output logic        we_,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(REG_NUM - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic        r_last_gnt;
    logic        r_we_n;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_clr_done;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_cnt_last;

    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pending clear outranks both requesters; ties go to whoever lost last time.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (clr_start) begin
                        w_state_nxt = S_CLEAR;
                    end else begin
                        w_gnt0 = req0_valid && (!req1_valid || r_last_gnt);
                        w_gnt1 = req1_valid && (!req0_valid || !r_last_gnt);
                    end
                end
                S_CLEAR: begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= 5'd0;
            r_last_gnt <= 1'b1;
            r_we_n     <= 1'b1;
            r_wr_addr  <= 5'd0;
            r_wr_data  <= 32'd0;
            r_clr_done <= 1'b0;
        end else begin
            r_we_n     <= 1'b1;
            r_clr_done <= 1'b0;
            if (r_state == S_CLEAR) begin
                r_we_n     <= 1'b0;
                r_wr_addr  <= r_cnt;
                r_wr_data  <= 32'd0;
                r_clr_done <= w_cnt_last;
                r_cnt      <= w_cnt_last ? 5'd0 : r_cnt + 5'd1;
            end else if (w_gnt0) begin
                r_we_n     <= 1'b0;
                r_wr_addr  <= req0_addr;
                r_wr_data  <= req0_data;
                r_last_gnt <= 1'b0;
            end else if (w_gnt1) begin
                r_we_n     <= 1'b0;
                r_wr_addr  <= req1_addr;
                r_wr_data  <= req1_data;
                r_last_gnt <= 1'b1;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign clr_busy   = (r_state == S_CLEAR);
    assign clr_done   = r_clr_done;
    assign we_        = r_we_n;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;

endmodule
